fetch_mem_ctrl: RTL and testbench
=================================

Name: fetch_mem_ctrl

Overview:
- Request/response sequencer between the front end's i-cache port and the i-cache/memory port.
- Forwards fetch address requests and limits how many requests are in flight.
- Drops every response that belongs to a request issued before a flush, so the front end only sees responses for post-flush requests.
- Responses are returned in order; the block keeps no per-request tags, only counters.

Parameters:
- MAX_OUT, 2, maximum outstanding (address accepted, response not yet consumed) requests; must be >= 1.
- CNT_W, $clog2(MAX_OUT+1), counter width (derived, not overridden).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  front-end flush (mispredict/exception), one-cycle pulse or level
- fe_addr_i  in  XLEN  fetch address from front end
- fe_addr_valid_i  in  1  front-end address valid
- fe_addr_ready_o  out  1  address accepted by this block
- fe_data_o  out  icache_out_t  response line+pc to front end
- fe_data_valid_o  out  1  response valid to front end
- fe_data_ready_i  in  1  front end can take response
- mem_addr_o  out  XLEN  address to i-cache
- mem_addr_valid_o  out  1  address valid to i-cache
- mem_addr_ready_i  in  1  i-cache accepts address
- mem_data_i  in  icache_out_t  response from i-cache
- mem_data_valid_i  in  1  i-cache response valid
- mem_data_ready_o  out  1  ready for i-cache response
- drain_o  out  1  high while stale responses remain to be dropped
- spurious_o  out  1  sticky error: response arrived with out_cnt==0

Behaviour:
- State registers:
  - out_cnt[CNT_W]: outstanding requests.
  - drop_cnt[CNT_W]: stale responses still to discard.
  - spurious flag.
  - All reset to 0 asynchronously.
- Derived state: NORMAL when drop_cnt==0, DRAIN when drop_cnt>0; drain_o = (drop_cnt!=0), registered-state based.
- Request path (combinational, zero latency):
  - mem_addr_o = fe_addr_i.
  - can_issue = !flush_i && (out_cnt < MAX_OUT).
  - mem_addr_valid_o = fe_addr_valid_i && can_issue.
  - fe_addr_ready_o = mem_addr_ready_i && can_issue.
  - req_fire = fe_addr_valid_i && fe_addr_ready_o.
  - Requests are allowed in DRAIN, because responses are in order.
- Response path:
  - fe_data_o = mem_data_i always.
  - A response is dropped when drop_cnt!=0 or flush_i is high.
  - If dropped: mem_data_ready_o=1 and fe_data_valid_o=0.
  - Otherwise: mem_data_ready_o=fe_data_ready_i and fe_data_valid_o=mem_data_valid_i.
  - rsp_fire = mem_data_valid_i && mem_data_ready_o.
- Counter update, each cycle:
  - out_cnt <= out_cnt + req_fire - rsp_fire. req_fire is 0 whenever flush_i is high.
  - If flush_i: drop_cnt <= out_cnt - rsp_fire. All remaining outstanding requests become stale; a second flush during DRAIN re-computes the same way.
  - Else if rsp_fire && drop_cnt!=0: drop_cnt <= drop_cnt - 1.
- Boundary conditions:
  - out_cnt==MAX_OUT: fe_addr_ready_o=0. A response and a request in the same cycle do not combine. The request waits until out_cnt has decremented, i.e. the following cycle.
  - Flush with out_cnt==0: drop_cnt stays 0 and NORMAL resumes next cycle.
  - Flush in the same cycle as a response: that response is dropped and not counted into drop_cnt.
  - rsp_fire with out_cnt==0: response is consumed and not forwarded; out_cnt stays 0 (saturate, no underflow); spurious_o set until reset.
  - Reset mid-operation: counters cleared; any responses for pre-reset requests are the i-cache's responsibility to discard.
- No backpressure from DRAIN onto flush_i: flush is always accepted.

Test Plan:
- Basic fetch: MAX_OUT=2; issue addr 0x100, i-cache ready, response pc=0x100 one cycle later with fe_data_ready_i=1 -> fe_data_valid_o=1 with pc 0x100; out_cnt returns to 0; drain_o stays 0.
- Outstanding limit: issue 0x100 and 0x104, withhold responses -> third request 0x108 sees fe_addr_ready_o=0 and mem_addr_valid_o=0. Return one response -> 0x108 accepted the next cycle.
- Flush drain:
  - Two requests outstanding, pulse flush_i -> drain_o=1 with drop_cnt=2.
  - Issue new addr 0x200 during DRAIN.
  - Responses 0x100 and 0x104 are accepted with fe_data_valid_o=0; response 0x200 is forwarded; drain_o=0 after the second drop.
- Flush coincident with response: out_cnt=2, response valid in the flush cycle -> response dropped, drop_cnt=1, out_cnt=1. Next response dropped, then NORMAL.
- Backpressure: response valid with fe_data_ready_i=0 in NORMAL -> mem_data_ready_o=0 and out_cnt held. Same condition in DRAIN -> mem_data_ready_o=1 and response dropped.
- Spurious/reset: response valid with out_cnt=0 -> spurious_o=1, fe_data_valid_o=0. Assert rst_n_i=0 mid-transfer -> all outputs and counters 0, spurious_o cleared.

Source files
------------

// File: rtl/fetch_mem_ctrl.sv
// Fetch request/response sequencer between the front end and the i-cache port.
// Bounds the number of in-flight requests and discards responses owed to pre-flush requests.
package fetch_mem_ctrl_pkg;
  parameter int XLEN   = 32;
  parameter int LINE_W = 128;

  typedef struct packed {
    logic [LINE_W-1:0] line;
    logic [XLEN-1:0]   pc;
  } icache_out_t;
endpackage

module fetch_mem_ctrl
  import fetch_mem_ctrl_pkg::*;
#(
  parameter  int MAX_OUT = 2,
  localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] fe_addr_i,
  input  logic            fe_addr_valid_i,
  output logic            fe_addr_ready_o,
  output icache_out_t     fe_data_o,
  output logic            fe_data_valid_o,
  input  logic            fe_data_ready_i,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_addr_valid_o,
  input  logic            mem_addr_ready_i,
  input  icache_out_t     mem_data_i,
  input  logic            mem_data_valid_i,
  output logic            mem_data_ready_o,
  output logic            drain_o,
  output logic            spurious_o
);

  // Handshake: a transfer happens in any cycle where valid and ready are both
  // high; valid never depends on ready on the same interface.

  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             spurious_q, spurious_d;

  logic can_issue;
  logic req_fire;
  logic rsp_fire;
  logic rsp_dec;
  logic rsp_drop;

  assign can_issue        = !flush_i && (out_cnt_q < CNT_W'(MAX_OUT));
  assign mem_addr_o       = fe_addr_i;
  assign mem_addr_valid_o = fe_addr_valid_i && can_issue;
  assign fe_addr_ready_o  = mem_addr_ready_i && can_issue;
  assign req_fire         = fe_addr_valid_i && fe_addr_ready_o;

  // A response with nothing outstanding is swallowed rather than forwarded.
  assign rsp_drop         = (drop_cnt_q != '0) || flush_i || (out_cnt_q == '0);
  assign fe_data_o        = mem_data_i;
  assign mem_data_ready_o = rsp_drop ? 1'b1 : fe_data_ready_i;
  assign fe_data_valid_o  = rsp_drop ? 1'b0 : mem_data_valid_i;
  assign rsp_fire         = mem_data_valid_i && mem_data_ready_o;
  assign rsp_dec          = rsp_fire && (out_cnt_q != '0);

  assign drain_o    = (drop_cnt_q != '0);
  assign spurious_o = spurious_q;

  always_comb begin
    out_cnt_d  = out_cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_dec);
    drop_cnt_d = drop_cnt_q;
    spurious_d = spurious_q;
    if (flush_i) begin
      drop_cnt_d = out_cnt_q - CNT_W'(rsp_dec);
    end else if (rsp_fire && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end
    if (rsp_fire && (out_cnt_q == '0)) begin
      spurious_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      spurious_q <= 1'b0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      spurious_q <= spurious_d;
    end
  end

endmodule

// File: tb/tb_fetch_mem_ctrl.sv
// Directed bench for fetch_mem_ctrl: fetch, outstanding limit, flush drain,
// backpressure, spurious response and asynchronous reset.
module tb_fetch_mem_ctrl;
  import fetch_mem_ctrl_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [XLEN-1:0] fe_addr;
  logic            fe_addr_valid;
  logic            fe_addr_ready;
  icache_out_t     fe_data;
  logic            fe_data_valid;
  logic            fe_data_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_addr_valid;
  logic            mem_addr_ready;
  icache_out_t     mem_data;
  logic            mem_data_valid;
  logic            mem_data_ready;
  logic            drain;
  logic            spurious;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  fetch_mem_ctrl #(.MAX_OUT(2)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .flush_i          (flush),
    .fe_addr_i        (fe_addr),
    .fe_addr_valid_i  (fe_addr_valid),
    .fe_addr_ready_o  (fe_addr_ready),
    .fe_data_o        (fe_data),
    .fe_data_valid_o  (fe_data_valid),
    .fe_data_ready_i  (fe_data_ready),
    .mem_addr_o       (mem_addr),
    .mem_addr_valid_o (mem_addr_valid),
    .mem_addr_ready_i (mem_addr_ready),
    .mem_data_i       (mem_data),
    .mem_data_valid_i (mem_data_valid),
    .mem_data_ready_o (mem_data_ready),
    .drain_o          (drain),
    .spurious_o       (spurious)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic idle();
    flush          = 1'b0;
    fe_addr        = '0;
    fe_addr_valid  = 1'b0;
    fe_data_ready  = 1'b1;
    mem_addr_ready = 1'b1;
    mem_data       = '0;
    mem_data_valid = 1'b0;
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [XLEN-1:0] a);
    fe_addr       = a;
    fe_addr_valid = 1'b1;
  endtask

  task automatic drive_rsp(input logic [XLEN-1:0] pc, input logic rdy);
    mem_data.pc    = pc;
    mem_data.line  = {4{pc}};
    mem_data_valid = 1'b1;
    fe_data_ready  = rdy;
  endtask

  task automatic issue(input logic [XLEN-1:0] a);
    idle();
    drive_req(a);
    step();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    mem_addr_ready = 1'b0;
    #12;
    check("rst_addr_ready", 64'(fe_addr_ready), 64'd0);
    check("rst_drain", 64'(drain), 64'd0);
    check("rst_spurious", 64'(spurious), 64'd0);
    check("rst_out_cnt", 64'(dut.out_cnt_q), 64'd0);
    idle();
    rst_n = 1'b1;
    step();

    // basic fetch
    drive_req(32'h100);
    #1;
    check("basic_mem_valid", 64'(mem_addr_valid), 64'd1);
    check("basic_addr_ready", 64'(fe_addr_ready), 64'd1);
    check("basic_mem_addr", 64'(mem_addr), 64'h100);
    step();
    idle();
    drive_rsp(32'h100, 1'b1);
    #1;
    check("basic_out1", 64'(dut.out_cnt_q), 64'd1);
    check("basic_fe_valid", 64'(fe_data_valid), 64'd1);
    check("basic_fe_pc", 64'(fe_data.pc), 64'h100);
    check("basic_fe_line", 64'(fe_data.line[63:0]), {32'h100, 32'h100});
    check("basic_mem_ready", 64'(mem_data_ready), 64'd1);
    step();
    idle();
    #1;
    check("basic_out0", 64'(dut.out_cnt_q), 64'd0);
    check("basic_drain", 64'(drain), 64'd0);

    // outstanding limit
    issue(32'h100);
    issue(32'h104);
    drive_req(32'h108);
    #1;
    check("lim_addr_ready", 64'(fe_addr_ready), 64'd0);
    check("lim_mem_valid", 64'(mem_addr_valid), 64'd0);
    drive_rsp(32'h100, 1'b1);
    #1;
    check("lim_rsp_valid", 64'(fe_data_valid), 64'd1);
    check("lim_same_cycle", 64'(fe_addr_ready), 64'd0);
    step();
    mem_data_valid = 1'b0;
    #1;
    check("lim_out1", 64'(dut.out_cnt_q), 64'd1);
    check("lim_next_ready", 64'(fe_addr_ready), 64'd1);
    check("lim_next_valid", 64'(mem_addr_valid), 64'd1);
    step();
    idle();
    #1;
    check("lim_out2", 64'(dut.out_cnt_q), 64'd2);

    // flush drain with 0x104, 0x108 outstanding
    flush = 1'b1;
    drive_req(32'h1f0);
    #1;
    check("fl_addr_ready", 64'(fe_addr_ready), 64'd0);
    check("fl_mem_valid", 64'(mem_addr_valid), 64'd0);
    step();
    idle();
    #1;
    check("fl_drain", 64'(drain), 64'd1);
    check("fl_drop2", 64'(dut.drop_cnt_q), 64'd2);
    check("fl_out2", 64'(dut.out_cnt_q), 64'd2);
    drive_rsp(32'h104, 1'b0);
    #1;
    check("fl_bp_mem_ready", 64'(mem_data_ready), 64'd1);
    check("fl_bp_fe_valid", 64'(fe_data_valid), 64'd0);
    step();
    idle();
    drive_req(32'h200);
    drive_rsp(32'h108, 1'b1);
    #1;
    check("fl_drop1", 64'(dut.drop_cnt_q), 64'd1);
    check("fl_drain_req_ready", 64'(fe_addr_ready), 64'd1);
    check("fl_stale_fe_valid", 64'(fe_data_valid), 64'd0);
    check("fl_stale_mem_ready", 64'(mem_data_ready), 64'd1);
    step();
    idle();
    #1;
    check("fl_drain_off", 64'(drain), 64'd0);
    check("fl_out1", 64'(dut.out_cnt_q), 64'd1);
    drive_rsp(32'h200, 1'b1);
    #1;
    check("fl_fwd_valid", 64'(fe_data_valid), 64'd1);
    check("fl_fwd_pc", 64'(fe_data.pc), 64'h200);
    step();
    idle();
    #1;
    check("fl_out0", 64'(dut.out_cnt_q), 64'd0);

    // flush coincident with a response
    issue(32'h300);
    issue(32'h304);
    flush = 1'b1;
    drive_rsp(32'h300, 1'b0);
    #1;
    check("co_mem_ready", 64'(mem_data_ready), 64'd1);
    check("co_fe_valid", 64'(fe_data_valid), 64'd0);
    step();
    idle();
    #1;
    check("co_drop1", 64'(dut.drop_cnt_q), 64'd1);
    check("co_out1", 64'(dut.out_cnt_q), 64'd1);
    drive_rsp(32'h304, 1'b1);
    #1;
    check("co_stale_fe_valid", 64'(fe_data_valid), 64'd0);
    step();
    idle();
    #1;
    check("co_drain_off", 64'(drain), 64'd0);
    check("co_out0", 64'(dut.out_cnt_q), 64'd0);

    // backpressure in NORMAL
    issue(32'h400);
    drive_rsp(32'h400, 1'b0);
    #1;
    check("bp_mem_ready", 64'(mem_data_ready), 64'd0);
    check("bp_fe_valid", 64'(fe_data_valid), 64'd1);
    step();
    #1;
    check("bp_out_held", 64'(dut.out_cnt_q), 64'd1);
    fe_data_ready = 1'b1;
    step();
    idle();
    #1;
    check("bp_out0", 64'(dut.out_cnt_q), 64'd0);

    // flush with nothing outstanding
    flush = 1'b1;
    step();
    idle();
    #1;
    check("fl0_drain", 64'(drain), 64'd0);
    check("fl0_drop", 64'(dut.drop_cnt_q), 64'd0);

    // spurious response
    drive_rsp(32'h500, 1'b1);
    #1;
    check("sp_fe_valid", 64'(fe_data_valid), 64'd0);
    check("sp_mem_ready", 64'(mem_data_ready), 64'd1);
    step();
    idle();
    #1;
    check("sp_flag", 64'(spurious), 64'd1);
    check("sp_out0", 64'(dut.out_cnt_q), 64'd0);

    // asynchronous reset mid-transfer
    issue(32'h600);
    #1;
    check("rs_out1", 64'(dut.out_cnt_q), 64'd1);
    mem_addr_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_out0", 64'(dut.out_cnt_q), 64'd0);
    check("rs_drop0", 64'(dut.drop_cnt_q), 64'd0);
    check("rs_spurious", 64'(spurious), 64'd0);
    check("rs_drain", 64'(drain), 64'd0);
    check("rs_fe_valid", 64'(fe_data_valid), 64'd0);
    check("rs_addr_ready", 64'(fe_addr_ready), 64'd0);
    check("rs_mem_valid", 64'(mem_addr_valid), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
